// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one result bit per cycle, with HI/LO ownership and pipeline stall generation.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] mf_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]      count_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dz_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH:0]   acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic is_mul_op, is_div_op, is_mf_op, is_mthi, is_mtlo, hilo_class, signed_op;
  logic accept, start;

  always_comb begin
    is_mul_op  = (funct == FUNC_MULT) || (funct == FUNC_MULTU);
    is_div_op  = (funct == FUNC_DIV)  || (funct == FUNC_DIVU);
    is_mf_op   = (funct == FUNC_MFHI) || (funct == FUNC_MFLO);
    is_mthi    = (funct == FUNC_MTHI);
    is_mtlo    = (funct == FUNC_MTLO);
    hilo_class = is_mul_op || is_div_op || is_mf_op || is_mthi || is_mtlo;
    signed_op  = (funct == FUNC_MULT) || (funct == FUNC_DIV);
    accept     = op_valid && !flush && (state_q == StIdle);
    start      = accept && (is_mul_op || is_div_op);
  end

  // Signed forms run on magnitudes; the sign is reapplied in FIX.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    a_neg = signed_op && rs_val[WIDTH-1];
    b_neg = signed_op && rt_val[WIDTH-1];
    mag_a = a_neg ? (~rs_val + 1'b1) : rs_val;
    mag_b = b_neg ? (~rt_val + 1'b1) : rt_val;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else if (count_q == '0) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = (state_q != StIdle);
    stall = op_valid && hilo_class && busy;
  end

  // ---------------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------------
  // Multiply: acc = {carry, partial product high, multiplier/product low}, shifted right.
  // Divide:   acc = {remainder (WIDTH+1), dividend/quotient}, shifted left.
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] mul_next;
  logic [2*WIDTH:0] div_shift;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH:0] div_next;
  logic [2*WIDTH:0] step_acc;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
    div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    div_next  = div_trial[WIDTH] ? div_shift
                                 : {div_trial, div_shift[WIDTH-1:1], 1'b1};
    step_acc  = is_div_q ? div_next : mul_next;
  end

  // ---------------------------------------------------------------------------
  // Sign correction
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] prod, prod_fixed;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    quo        = acc_q[WIDTH-1:0];
    rem        = acc_q[2*WIDTH-1:WIDTH];
    prod       = acc_q[2*WIDTH-1:0];
    prod_fixed = neg_res_q ? (~prod + 1'b1) : prod;
    if (is_div_q) begin
      // Divide by zero leaves an all-ones quotient regardless of operand signs.
      fix_lo = (neg_res_q && !dz_q) ? (~quo + 1'b1) : quo;
      fix_hi = neg_rem_q ? (~rem + 1'b1) : rem;
    end else begin
      fix_lo = prod_fixed[WIDTH-1:0];
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == StFix) && !flush;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            count_q   <= CW'(WIDTH - 1);
            is_div_q  <= is_div_op;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= (rt_val == '0);
            if (is_div_op) begin
              opnd_q <= mag_b;
              acc_q  <= {{(WIDTH + 1){1'b0}}, mag_a};
            end else begin
              opnd_q <= mag_a;
              acc_q  <= {{(WIDTH + 1){1'b0}}, mag_b};
            end
          end else if (accept && is_mthi) begin
            hi_q <= rs_val;
          end else if (accept && is_mtlo) begin
            lo_q <= rs_val;
          end
        end
        StRun: begin
          if (!flush) begin
            acc_q   <= step_acc;
            count_q <= count_q - 1'b1;
          end
        end
        StFix: begin
          if (!flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hi   = hi_q;
    lo   = lo_q;
    done = done_q;
    if (funct == FUNC_MFHI) begin
      mf_result = hi_q;
    end else if (funct == FUNC_MFLO) begin
      mf_result = lo_q;
    end else begin
      mf_result = '0;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle compare, with directed
// literal checks on the documented corner cases.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic [5:0]   funct;
  logic [W-1:0] rs_val, rt_val;
  logic         flush;
  logic         busy, stall, done;
  logic [W-1:0] mf_result, hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp  = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .funct    (funct),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .mf_result(mf_result),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      MULT:    return 64'(sa * sb);
      MULTU:   return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (f == DIV) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  function automatic bit is_hilo(input logic [5:0] f);
    return (f inside {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU});
  endfunction

  // Model: remaining busy cycles, pending result, architectural HI/LO.
  int          m_cnt  = 0;
  logic [63:0] m_pend = '0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic        m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        if (flush) begin
          m_cnt <= 0;
        end else if (m_cnt == 1) begin
          m_cnt  <= 0;
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (op_valid && !flush) begin
        if (funct inside {MULT, MULTU, DIV, DIVU}) begin
          m_cnt  <= W + 1;
          m_pend <= ref_result(funct, rs_val, rt_val);
        end else if (funct == MTHI) begin
          m_hi <= rs_val;
        end else if (funct == MTLO) begin
          m_lo <= rs_val;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_busy", 64'(busy), 64'(m_cnt != 0));
      chk("cmp_stall", 64'(stall), 64'(op_valid && is_hilo(funct) && m_cnt != 0));
      chk("cmp_done", 64'(done), 64'(m_done));
      chk("cmp_hi", 64'(hi), 64'(m_hi));
      chk("cmp_lo", 64'(lo), 64'(m_lo));
      chk("cmp_mf", 64'(mf_result),
          64'((funct == MFHI) ? m_hi : (funct == MFLO) ? m_lo : 32'd0));
    end
  end

  // Called at #1 after a posedge; presents an op for exactly one edge.
  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    funct    = f;
    rs_val   = a;
    rt_val   = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = busy ? 1 : 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) nbusy++;
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int lat, nb;
    drive(f, a, b);
    wait_done(lat, nb);
    chk({name, "_lat"}, 64'(lat), 64'd33);
    chk({name, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({name, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int lat, nb, ndone;
    op_valid = 1'b0;
    funct    = 6'h00;
    rs_val   = '0;
    rt_val   = '0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst_n   = 1'b1;
    run_cmp = 1'b1;

    // Unsigned max product, latency and busy length.
    drive(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, nb);
    chk("t1_lat", 64'(lat), 64'd33);
    chk("t1_busy_cycles", 64'(nb), 64'd33);
    chk("t1_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("t1_lo", 64'(lo), 64'h0000_0001);

    // Signed multiply with MFLO held from the cycle after accept.
    drive(MULT, 32'hFFFF_FFF9, 32'd3);
    op_valid = 1'b1;
    funct    = MFLO;
    #1;
    chk("t2_stall", 64'(stall), 64'd1);
    wait_done(lat, nb);
    chk("t2_lat", 64'(lat), 64'd33);
    chk("t2_mflo", 64'(mf_result), 64'hFFFF_FFEB);
    chk("t2_nostall", 64'(stall), 64'd0);
    chk("t2_hi", 64'(hi), 64'hFFFF_FFFF);
    op_valid = 1'b0;

    // Divides, issued back-to-back in each done cycle.
    run_op("t3_div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("t3_divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("t3_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("t3_div_negb", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("t3_sdz", DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
    run_op("t4_udz", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

    // MTHI/MTLO in IDLE, MF readback, flush and non-HI/LO functs blocked.
    op_valid = 1'b1;
    funct    = MTHI;
    rs_val   = 32'hA5A5_A5A5;
    #1;
    chk("t4_mthi_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    chk("t4_mthi", 64'(hi), 64'hA5A5_A5A5);
    drive(MTLO, 32'h5A5A_0001, 32'd0);
    chk("t4_mtlo", 64'(lo), 64'h5A5A_0001);
    op_valid = 1'b1;
    funct    = MFHI;
    #1;
    chk("t4_mfhi", 64'(mf_result), 64'hA5A5_A5A5);
    funct  = MTLO;
    rs_val = 32'h1234_5678;
    flush  = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("t4_flush_mt", 64'(lo), 64'h5A5A_0001);
    drive(6'h20, 32'd1, 32'd2);
    chk("t4_ignored", 64'(busy), 64'd0);

    // Flush mid-RUN: no done, HI/LO untouched.
    drive(MULT, 32'd12345, 32'd678);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("t5_nodone", 64'(ndone), 64'd0);
    chk("t5_hi", 64'(hi), 64'hA5A5_A5A5);
    chk("t5_lo", 64'(lo), 64'h5A5A_0001);

    // Flush in the FIX cycle wins over the write.
    drive(MULTU, 32'd3, 32'd3);
    repeat (32) @(posedge clk);
    #1;
    chk("t5_fix_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("t5_fix_done", 64'(done), 64'd0);
    chk("t5_fix_lo", 64'(lo), 64'h5A5A_0001);

    // Asynchronous reset mid-divide, then a fresh multiply.
    drive(DIV, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_hi", 64'(hi), 64'd0);
    chk("t6_lo", 64'(lo), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("t6_mult", MULT, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (3) @(posedge clk);
    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
